inst_queue: RTL

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 78 +++++++
 1 files changed

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a circular buffer with a separate
// occupancy counter. Entries appear at the head one cycle after they are pushed.
module inst_queue #(
  parameter int BUS_WD   = 64,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [BUS_WD-1:0]            in_bus,
  output logic                         in_allowin,
  output logic                         out_valid,
  output logic [BUS_WD-1:0]            out_bus,
  input  logic                         out_allowin,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [BUS_WD-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;

  // A full queue still accepts when the head leaves in the same cycle.
  assign in_allowin  = (count_q < CNT_W'(DEPTH)) || out_allowin;
  assign out_valid   = (count_q != '0);
  assign out_bus     = mem[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= CNT_W'(AF_LEVEL));

  assign push = in_valid && in_allowin && !flush;
  assign pop  = out_valid && out_allowin && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_bus;
  end

endmodule
